digit_serial_negator: RTL

Parametrised digit-serial two's-complement unit: accepts a WORD_W-bit word LSB-first, DIGIT_W bits per cycle, and emits it either negated or unchanged, one registered digit per accepted input digit. It generalises our single-bit serial complementer:
- configurable word and digit width;
- explicit word framing with valid/stall;
- per-word negate/pass mode;
- last-digit marker;
- overflow detection for the most negative value.

It sits between serial datapath stages that already stream LSB-first.

---
 rtl/digit_serial_negator.sv | 62 ++++++
 1 files changed

// File: rtl/digit_serial_negator.sv
// digit_serial_negator: LSB-first digit-serial two's-complement negate/pass unit with word framing and overflow flag
module digit_serial_negator #(
    parameter int WORD_W  = 16,
    parameter int DIGIT_W = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               validIn,
    input  logic               negate,
    input  logic [DIGIT_W-1:0] digitIn,
    output logic [DIGIT_W-1:0] digitOut,
    output logic               validOut,
    output logic               lastOut,
    output logic               ovf,
    output logic               busy
);
    localparam int NDIG = WORD_W / DIGIT_W;
    localparam int CW = NDIG > 1 ? $clog2(NDIG) : 1;
    localparam logic [DIGIT_W-1:0] TOP_BIT = DIGIT_W'(1) << (DIGIT_W - 1);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_base;
    logic seen_one, seen_n, neg_reg, neg_n;
    logic accept, s, neg, last, ovf_n;
    logic [DIGIT_W-1:0] out_n;
    always_comb begin
        accept   = validIn & (start | (state == ACTIVE));
        s        = start ? 1'b0 : seen_one;
        neg      = start ? negate : neg_reg;
        cnt_base = start ? '0 : cnt;
        last     = start ? (NDIG == 1) : (cnt == CW'(NDIG - 1));
        out_n    = neg ? (~digitIn + DIGIT_W'(!s)) : digitIn;
        ovf_n    = neg & !s & (digitIn == TOP_BIT) & last;
        state_n  = accept ? (last ? IDLE : ACTIVE) : state;
        cnt_n    = accept ? (last ? '0 : cnt_base + CW'(1)) : cnt;
        seen_n   = accept ? (!last & (s | (digitIn != '0))) : seen_one;
        neg_n    = (accept & start) ? negate : neg_reg;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            seen_one <= 1'b0;
            neg_reg  <= 1'b0;
            digitOut <= '0;
            validOut <= 1'b0;
            lastOut  <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            seen_one <= seen_n;
            neg_reg  <= neg_n;
            digitOut <= accept ? out_n : digitOut;
            validOut <= accept;
            lastOut  <= accept & last;
            ovf      <= accept & ovf_n;
        end
    end
    assign busy = (state == ACTIVE);
endmodule
